// File: rtl/map_arb_pkg.sv
// Map RAM arbiter: shared widths, arbitration states
// and read-return owner tags.
package map_arb_pkg;

   localparam int MAP_ADDR_W = 15;
   localparam int MAP_DATA_W = 2;
   localparam int STARVE_W   = 4;

   typedef enum logic [1:0] {
      VID_PRI = 2'd0,
      CPU_PRI = 2'd1,
      FORCE   = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_e;

endpackage

// File: rtl/map_arb_starve_ctr.sv
// Saturating count of cycles the CPU has waited for a grant.
module map_arb_starve_ctr
   import map_arb_pkg::*;
#(
   parameter logic [STARVE_W-1:0] MAX = 4'd15
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                inc_i,
   input  logic                clr_i,
   output logic [STARVE_W-1:0] cnt_o,
   output logic [STARVE_W-1:0] cnt_d_o
);

   logic [STARVE_W-1:0] cnt_q;
   logic [STARVE_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < MAX)) begin
         cnt_d = cnt_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign cnt_d_o = cnt_d;

endmodule

// File: rtl/map_arbiter.sv
// Single-port map RAM arbiter between video scan-out
// and CPU, with starvation forcing and in-order read return.
module map_arbiter
   import map_arb_pkg::*;
#(
   parameter int ADDR_W     = MAP_ADDR_W,
   parameter int DATA_W     = MAP_DATA_W,
   parameter int STARVE_MAX = 15
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              video_on,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              vid_rvalid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [3:0]        starve_cnt
);

   localparam logic [STARVE_W-1:0] SMAX =
      STARVE_W'(STARVE_MAX);

   arb_state_e          state_q, state_d;
   owner_e              tag1_q, tag1_d, tag2_q;
   logic [STARVE_W-1:0] cnt_d;
   logic                cpu_first;
   logic                ram_en_q, ram_we_q;
   logic [ADDR_W-1:0]   ram_addr_q;
   logic [DATA_W-1:0]   ram_wdata_q;
   logic [DATA_W-1:0]   vid_rdata_q, cpu_rdata_q;

   map_arb_starve_ctr #(
      .MAX (SMAX)
   ) u_starve (
      .clk_i   (clock),
      .rst_ni  (rst_n),
      .inc_i   (cpu_req & ~cpu_gnt),
      .clr_i   (cpu_gnt),
      .cnt_o   (starve_cnt),
      .cnt_d_o (cnt_d)
   );

   // Gated by rst_n so both grants read 0 while in reset.
   assign cpu_first = (state_q != VID_PRI);
   assign vid_gnt = rst_n & vid_req & (~cpu_req | ~cpu_first);
   assign cpu_gnt = rst_n & cpu_req & (~vid_req | cpu_first);

   always_comb begin
      state_d = VID_PRI;
      if (!video_on) begin
         state_d = CPU_PRI;
      end else if (cnt_d == SMAX) begin
         state_d = FORCE;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= VID_PRI;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      unique case (1'b1)
         (cpu_gnt && !cpu_we): tag1_d = OWN_CPU;
         vid_gnt:              tag1_d = OWN_VID;
         default:              tag1_d = OWN_NONE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         tag1_q      <= OWN_NONE;
         tag2_q      <= OWN_NONE;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         vid_rdata_q <= '0;
         cpu_rdata_q <= '0;
      end else begin
         tag1_q   <= tag1_d;
         tag2_q   <= tag1_q;
         ram_en_q <= vid_gnt | cpu_gnt;
         ram_we_q <= cpu_gnt & cpu_we;
         if (cpu_gnt) begin
            ram_addr_q  <= cpu_addr;
            ram_wdata_q <= cpu_wdata;
         end else if (vid_gnt) begin
            ram_addr_q  <= vid_addr;
            ram_wdata_q <= '0;
         end
         if (vid_rvalid) vid_rdata_q <= ram_rdata;
         if (cpu_rvalid) cpu_rdata_q <= ram_rdata;
      end
   end

   // RAM data lands in the tag2 cycle, so it is passed straight through.
   assign vid_rvalid = (tag2_q == OWN_VID);
   assign cpu_rvalid = (tag2_q == OWN_CPU);
   assign vid_rdata  = vid_rvalid ? ram_rdata : vid_rdata_q;
   assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_q;

   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/map_arbiter.md
MAP_ARBITER -- requirements
Module: map_arbiter

Interface
REQ-001 Parameter: ADDR_W, 15, map RAM address width ({row[6:0], col[7:0]} of the 120x160 4x4-pixel grid).
REQ-002 Parameter: DATA_W, 2, map cell width.
REQ-003 Parameter: STARVE_MAX, 15, maximum number of cycles a blocked CPU request waits before it is forced through.
REQ-004 Port: clock  in  1  system clock; the block uses one clock only.
REQ-005 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-006 Port: video_on  in  1  display-active flag from the timing generator.
REQ-007 Video request ports:
- vid_req  in  1
- vid_addr  in  ADDR_W
- vid_gnt  out  1
- vid_rdata  out  DATA_W
- vid_rvalid  out  1
REQ-008 CPU request ports:
- cpu_req  in  1
- cpu_we  in  1
- cpu_addr  in  ADDR_W
- cpu_wdata  in  DATA_W
- cpu_gnt  out  1
- cpu_rdata  out  DATA_W
- cpu_rvalid  out  1
REQ-009 RAM ports:
- ram_en  out  1
- ram_we  out  1
- ram_addr  out  ADDR_W
- ram_wdata  out  DATA_W
- ram_rdata  in  DATA_W; the single-port RAM returns data one cycle after ram_en.
REQ-010 Port: starve_cnt  out  4  current CPU wait count, for debug display.

Function
REQ-011 Handshake: a requester holds req, addr, we and wdata stable until the cycle in which req and gnt are both high; the transfer occurs in that cycle.
REQ-012 Grants are combinational from the current req, mode and counter, and are never both high in the same cycle.
REQ-013 The arbiter is a three-state FSM with the following states:
- VID_PRI: entered when video_on=1 and starve_cnt<STARVE_MAX.
- CPU_PRI: entered when video_on=0.
- FORCE: entered when video_on=1 and starve_cnt==STARVE_MAX.
- The state is registered and evaluated every cycle.
REQ-014 Grant rules by state:
- VID_PRI: video wins any conflict.
- CPU_PRI: CPU wins any conflict.
- FORCE: CPU wins any conflict for exactly one grant, then returns to VID_PRI.
- A lone requester is granted in every state.
REQ-015 The cycle after a grant, the RAM command is registered out:
- ram_en=1.
- ram_we=cpu_we for a CPU grant, 0 for a video grant.
- ram_addr and ram_wdata are taken from the granted requester.
REQ-016 Read return:
- A 2-stage owner tag pipeline routes ram_rdata.
- rvalid pulses on the granted port exactly 2 cycles after the gnt cycle, with rdata valid in that cycle.
- A CPU write produces no rvalid.
REQ-017 Throughput is one grant per cycle; back-to-back grants, including alternating owners, are legal and each returns in order.
REQ-018 Starvation counter:
- Increments each cycle cpu_req=1 and cpu_gnt=0.
- Saturates at STARVE_MAX.
- Clears to 0 in the cycle after cpu_gnt=1.
- Holds while cpu_req=0.
REQ-019 If video_on falls while in FORCE, the next state is CPU_PRI; the pending force is absorbed and the counter clears on the next CPU grant.
REQ-020 rdata outputs hold their last value when rvalid=0.

Reset
REQ-021 While rst_n=0, all of the following are 0: outputs, FSM state (VID_PRI), starve_cnt, and owner tags.
REQ-022 Reads in flight when reset asserts are dropped: no rvalid is produced after reset releases.
REQ-023 The first grant is possible in the first cycle after rst_n rises.

Structure
REQ-024 Package map_arb_pkg holds:
- ADDR_W and DATA_W defaults.
- The FSM state encoding {VID_PRI, CPU_PRI, FORCE}.
- The owner tag encoding {OWN_NONE, OWN_VID, OWN_CPU}.
REQ-025 One sub-module, map_arb_starve_ctr, is natural: the saturating counter with clear.

Verification
REQ-026 video_on=1; vid_req and cpu_req both high continuously -> vid_gnt=1 for 15 cycles, then cpu_gnt=1 for 1 cycle, then vid_gnt resumes; starve_cnt goes 0..15, then back to 0.
REQ-027 video_on=0; cpu_req=1, cpu_we=0, cpu_addr=0x0123 with a RAM preloaded with 2'b10 at that address -> ram_en 1 cycle after gnt; cpu_rvalid=1 with cpu_rdata=2'b10 2 cycles after gnt.
REQ-028 video_on=0; CPU write 2'b11 to 0x4A5F and a simultaneous vid_req -> cpu_gnt first and ram_we=1; vid_gnt the next cycle; no cpu_rvalid.
REQ-029 Alternating video and CPU reads every cycle -> one grant per cycle; rvalids arrive in grant order with correct owner.
REQ-030 Assert rst_n=0 one cycle after a vid_gnt -> no vid_rvalid after release; all outputs 0 during reset.
REQ-031 video_on=1 with starve_cnt=15, then video_on drops in the same cycle -> state CPU_PRI; cpu_gnt next cycle; starve_cnt returns to 0.
